alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_arb_grant.sv | 13 +
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int OPW_DEF  = 4;

  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arb_grant.sv
// Two-way grant: a lone requester always wins; on a tie the pointer decides.
module alu_arb_grant (
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (&valid) grant = pointer ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters (IDLE/EXEC/RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority to 0.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int OPW  = OPW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp0_zero,
  output logic            rsp0_carry,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic            rsp1_zero,
  output logic            rsp1_carry,
  output logic [XLEN-1:0] alu_in_1,
  output logic [XLEN-1:0] alu_in_2,
  output logic [OPW-1:0]  alu_opcode,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  input  logic            alu_carry
);

  state_t          state;
  state_t          state_nxt;
  logic [OPW-1:0]  op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] res_q;
  logic            zero_q;
  logic            carry_q;
  logic            owner;
  logic            ptr;
  logic [1:0]      grant;
  logic            open;
  logic            accept;
  logic            done;

  alu_arb_grant u_grant (
    .valid   ({req1_valid, req0_valid}),
    .pointer (ptr),
    .grant   (grant)
  );

  assign open       = (state == IDLE) && !rst;
  assign req0_ready = open && grant[0];
  assign req1_ready = open && grant[1];
  assign accept     = open && |grant;
  assign done       = (state == RESP) &&
                      (owner ? rsp1_ready : rsp0_ready);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Favour the requester that was not served last.
  always_ff @(posedge clk) begin
    if (rst) ptr <= 1'b0;
    else if (done) ptr <= ~owner;
  end
`else
  assign ptr = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      owner   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner <= grant[1];
        op_q  <= grant[1] ? req1_op : req0_op;
        a_q   <= grant[1] ? req1_a : req0_a;
        b_q   <= grant[1] ? req1_b : req0_b;
      end
      if (state == EXEC) begin
        res_q   <= alu_out;
        zero_q  <= alu_zero;
        carry_q <= alu_carry;
      end
    end
  end

  assign alu_in_1   = a_q;
  assign alu_in_2   = b_q;
  assign alu_opcode = (state == EXEC) ? op_q : '0;

  assign rsp0_valid  = (state == RESP) && !owner;
  assign rsp1_valid  = (state == RESP) && owner;
  assign rsp0_result = owner ? '0 : res_q;
  assign rsp0_zero   = !owner && zero_q;
  assign rsp0_carry  = !owner && carry_q;
  assign rsp1_result = owner ? res_q : '0;
  assign rsp1_zero   = owner && zero_q;
  assign rsp1_carry  = owner && carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a small reference ALU attached.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_carry;
  logic [31:0] rsp0_result;
  logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_carry;
  logic [31:0] rsp1_result;
  logic [31:0] alu_in_1, alu_in_2, alu_out;
  logic [3:0]  alu_opcode;
  logic        alu_zero, alu_carry;

  typedef struct {
    int          owner;
    logic [31:0] res;
    logic        z;
    logic        c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   r1_cnt = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp0_carry(rsp0_carry),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .rsp1_carry(rsp1_carry),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry)
  );

  // Reference ALU: undecoded opcodes (including 0) return 0.
  always_comb begin
    alu_out   = 32'd0;
    alu_carry = 1'b0;
    case (alu_opcode)
      4'd1: {alu_carry, alu_out} = {1'b0, alu_in_1} + {1'b0, alu_in_2};
      4'd2: begin
        alu_out   = alu_in_1 - alu_in_2;
        alu_carry = alu_in_1 < alu_in_2;
      end
      4'd3: alu_out = alu_in_1 & alu_in_2;
      4'd4: alu_out = alu_in_1 | alu_in_2;
      4'd5: alu_out = alu_in_1 ^ alu_in_2;
      default: alu_out = 32'd0;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d",
               name, act, exp, cyc);
    end
  endfunction

  function automatic void push(input int o, input logic [31:0] r,
                               input logic z, input logic c);
    exp_t e;
    e.owner = o;
    e.res   = r;
    e.z     = z;
    e.c     = c;
    sb.push_back(e);
  endfunction

  task automatic pop_check(input int n, input logic [31:0] r,
                           input logic z, input logic c,
                           input logic other);
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_rsp", 32'(n) + 1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("rsp_owner", 32'(n), 32'(e.owner));
      chk("rsp_result", r, e.res);
      chk("rsp_zero", {31'd0, z}, {31'd0, e.z});
      chk("rsp_carry", {31'd0, c}, {31'd0, e.c});
      chk("nonowner_quiet", {31'd0, other}, 32'd0);
    end
  endtask

  // Monitor: compares every delivered response against the scoreboard.
  always @(negedge clk) begin
    if (req1_ready) r1_cnt++;
    if (rsp0_valid && rsp0_ready)
      pop_check(0, rsp0_result, rsp0_zero, rsp0_carry,
                rsp1_valid | (|rsp1_result) | rsp1_zero | rsp1_carry);
    if (rsp1_valid && rsp1_ready)
      pop_check(1, rsp1_result, rsp1_zero, rsp1_carry,
                rsp0_valid | (|rsp0_result) | rsp0_zero | rsp0_carry);
  end

  task automatic send(input int n, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      output int acc);
    int t;
    acc = -1;
    if (n == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    t = 0;
    while (acc < 0 && t < 50) begin
      @(negedge clk);
      t++;
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) acc = cyc;
    end
    chk("accept", {31'd0, acc >= 0}, 32'd1);
    @(posedge clk); #1;
    if (n == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  int acc, t, n, prev, base;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_rsp0_result", rsp0_result, 32'd0);
    chk("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    chk("rst_alu_in", alu_in_1 | alu_in_2, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // V1: ADD 5+7, latency 2 cycles from accept to rsp valid
    push(0, 32'd12, 1'b0, 1'b0);
    send(0, 4'd1, 32'd5, 32'd7, acc);
    t = 0;
    while (t < 20) begin
      @(negedge clk);
      t++;
      chk("v1_rsp1_idle", {31'd0, rsp1_valid}, 32'd0);
      if (rsp0_valid) break;
    end
    chk("v1_latency", 32'(cyc - acc), 32'd2);
    drain();

    // Carry-out with wrap to zero
    push(0, 32'd0, 1'b1, 1'b1);
    send(0, 4'd1, 32'hFFFF_FFFF, 32'd1, acc);
    drain();

    // Lone requester 1: ADD 2+3
    push(1, 32'd5, 1'b0, 1'b0);
    send(1, 4'd1, 32'd2, 32'd3, acc);
    drain();

    // V2: both requesters valid for four operations
`ifdef ALU_ARB_ROUND_ROBIN_EN
    push(0, 32'd11, 1'b0, 1'b0);
    push(1, 32'd22, 1'b0, 1'b0);
    push(0, 32'd11, 1'b0, 1'b0);
    push(1, 32'd22, 1'b0, 1'b0);
`else
    for (int i = 0; i < 4; i++) push(0, 32'd11, 1'b0, 1'b0);
`endif
    req0_op = 4'd1; req0_a = 32'd10; req0_b = 32'd1; req0_valid = 1'b1;
    req1_op = 4'd1; req1_a = 32'd20; req1_b = 32'd2; req1_valid = 1'b1;
    n = 0; t = 0; prev = -1;
    while (n < 4 && t < 60) begin
      @(negedge clk);
      t++;
      if (req0_ready || req1_ready) begin
        chk("v2_onehot", {30'd0, req1_ready, req0_ready} & 32'd3,
            req1_ready ? 32'd2 : 32'd1);
        if (prev >= 0) chk("v2_throughput", 32'(cyc - prev), 32'd3);
        prev = cyc;
        n++;
      end
    end
    chk("v2_accepts", 32'(n), 32'd4);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // V3: SUB 9-9 held in RESP while rsp0_ready is low
    rsp0_ready = 1'b0;
    push(0, 32'd0, 1'b1, 1'b0);
    push(1, 32'd5, 1'b0, 1'b0);
    send(0, 4'd2, 32'd9, 32'd9, acc);
    req1_op = 4'd1; req1_a = 32'd2; req1_b = 32'd3; req1_valid = 1'b1;
    t = 0;
    while (t < 20) begin
      @(negedge clk);
      t++;
      chk("v3_req1_ready_exec", {31'd0, req1_ready}, 32'd0);
      if (rsp0_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("v3_hold_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("v3_hold_result", rsp0_result, 32'd0);
      chk("v3_hold_zero", {31'd0, rsp0_zero}, 32'd1);
      chk("v3_req1_ready", {31'd0, req1_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    t = 0;
    while (!req1_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("v3_req1_served", {31'd0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();

    // V4: reset during EXEC discards the operation
    send(0, 4'd1, 32'd1, 32'd1, acc);
    rst = 1'b1;
    push(0, 32'd13, 1'b0, 1'b0);
    req0_op = 4'd1; req0_a = 32'd6; req0_b = 32'd7; req0_valid = 1'b1;
    @(negedge clk);
    chk("v4_rst_ready", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("v4_no_rsp", {31'd0, rsp0_valid}, 32'd0);
    chk("v4_in_cleared", alu_in_1, 32'd0);
    chk("v4_idle_ready", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drain();

    // V5: undecoded opcode 15 is forwarded only during EXEC
    push(0, 32'd0, 1'b1, 1'b0);
    send(0, 4'd15, 32'd3, 32'd4, acc);
    @(negedge clk);
    chk("v5_exec_opcode", {28'd0, alu_opcode}, 32'd15);
    chk("v5_exec_in1", alu_in_1, 32'd3);
    chk("v5_exec_in2", alu_in_2, 32'd4);
    @(negedge clk);
    chk("v5_resp_opcode", {28'd0, alu_opcode}, 32'd0);
    chk("v5_resp_in1", alu_in_1, 32'd3);
    drain();

    // V6: req1 withdraws while busy; req0 arrives later
    base = r1_cnt;
    rsp0_ready = 1'b0;
    push(0, 32'd8, 1'b0, 1'b0);
    send(0, 4'd1, 32'd4, 32'd4, acc);
    req1_op = 4'd1; req1_a = 32'd1; req1_b = 32'd1; req1_valid = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    push(0, 32'd7, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send(0, 4'd2, 32'd10, 32'd3, acc);
    drain();
    chk("v6_req1_never_ready", 32'(r1_cnt - base), 32'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
